// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchronizer, oversampled start/data/stop
// detection driven by an external baud tick, and a one-cycle completion
// pulse with a stop-bit framing error flag.
module uart_rx #(
  parameter int D_W    = 8,
  parameter int B_TICK = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baud_clk,
  input  logic           rx_data,
  output logic [D_W-1:0] output_data,
  output logic           rx_done,
  output logic           frame_err,
  output logic           rx_busy
);

  localparam int TW = (B_TICK > 1) ? $clog2(B_TICK) : 1;
  localparam int BW = (D_W > 1) ? $clog2(D_W) : 1;

  localparam logic [TW-1:0] TICK_HALF = TW'(B_TICK / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(B_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(D_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t         state_q, state_d;
  logic           sync1_q, sync1_d;
  logic           rx_s_q, rx_s_d;       // synchronized serial line
  logic           init_q, init_d;       // first cycle after reset release has passed
  logic           arm_q, arm_d;         // line seen high in IDLE; a low now is a real start edge
  logic [TW-1:0]  tick_q, tick_d;
  logic [BW-1:0]  bit_q, bit_d;
  logic [D_W-1:0] shift_q, shift_d;
  logic [D_W-1:0] data_q, data_d;
  logic           done_q, done_d;
  logic           ferr_q, ferr_d;

  assign output_data = data_q;
  assign rx_done     = done_q;
  assign frame_err   = ferr_q;
  assign rx_busy     = (state_q != IDLE);

  // Next-state logic for the synchronizer, receive FSM, counters and outputs.
  always_comb begin
    sync1_d = rx_data;
    rx_s_d  = sync1_q;
    init_d  = 1'b1;
    state_d = state_q;
    arm_d   = arm_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Arm only once both synchronizer stages show a real high line, so the
        // reset value of the synchronizer or a line held low never looks like an edge.
        if (init_q && rx_s_q && sync1_q) begin
          arm_d = 1'b1;
        end
        if (arm_q && !rx_s_q) begin
          state_d = START;
          tick_d  = '0;
          arm_d   = 1'b0;
        end
      end
      START: begin
        if (baud_clk) begin
          if (tick_q == TICK_HALF) begin
            if (!rx_s_q) begin
              state_d = DATA;
              tick_d  = '0;
              bit_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      DATA: begin
        if (baud_clk) begin
          if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            shift_d = {rx_s_q, shift_q[D_W-1:1]};
            if (bit_q == BIT_LAST) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      STOP: begin
        if (baud_clk) begin
          if (tick_q == TICK_LAST) begin
            state_d = IDLE;
            tick_d  = '0;
            data_d  = shift_q;
            done_d  = 1'b1;
            ferr_d  = !rx_s_q;
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; asynchronous reset aborts any frame in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      init_q  <= 1'b0;
      arm_q   <= 1'b0;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= sync1_d;
      rx_s_q  <= rx_s_d;
      init_q  <= init_d;
      arm_q   <= arm_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

endmodule
